// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the register-file writeback arbiter:
// register-file geometry, slot state encoding and a decode helper.
package regfile_wb_arbiter_pkg;

  localparam int RF_DATA_W   = 16;
  localparam int RF_ADDR_W   = 4;
  localparam int RF_NUM_REGS = 16;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // One-hot decode of a register address, used by the pending-write scoreboard.
  function automatic logic [RF_NUM_REGS-1:0] addr_onehot(input logic [RF_ADDR_W-1:0] addr);
    logic [RF_NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback sources, the arbiter and the
// register-file write port. The arbiter connects through the slave modport.
interface regfile_wb_arbiter_if;
  import regfile_wb_arbiter_pkg::*;

  logic                   alu_valid;
  logic                   alu_ready;
  logic [RF_ADDR_W-1:0]   alu_addr;
  logic [RF_DATA_W-1:0]   alu_data;

  logic                   mem_valid;
  logic                   mem_ready;
  logic [RF_ADDR_W-1:0]   mem_addr;
  logic [RF_DATA_W-1:0]   mem_data;

  logic                   reg3_write;
  logic [RF_ADDR_W-1:0]   reg3_addr;
  logic [RF_DATA_W-1:0]   reg3_bus;

  logic [RF_NUM_REGS-1:0] pending_mask;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready,
    input  reg3_write, reg3_addr, reg3_bus, pending_mask
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready,
    output reg3_write, reg3_addr, reg3_bus, pending_mask
  );

endinterface

// File: rtl/regfile_wb_arbiter_wb_slot.sv
// One-entry holding slot for a writeback source. Accepts on valid && ready,
// and may drain (when granted) and refill on the same edge.
module wb_slot
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 valid,
  input  logic [RF_ADDR_W-1:0] addr,
  input  logic [RF_DATA_W-1:0] data,
  input  logic                 grant,
  output logic                 ready,
  output logic                 accept,
  output logic                 full,
  output logic [RF_ADDR_W-1:0] held_addr,
  output logic [RF_DATA_W-1:0] held_data
);

  slot_state_e state, state_next;

  assign ready  = (state == SLOT_EMPTY) || grant;
  assign accept = valid && ready;
  assign full   = (state == SLOT_FULL);

  // Slot occupancy register, cleared asynchronously so held writes are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SLOT_EMPTY;
    else        state <= state_next;
  end

  // Refill wins over drain; a granted slot with no refill empties.
  always_comb begin
    state_next = state;
    if (accept)     state_next = SLOT_FULL;
    else if (grant) state_next = SLOT_EMPTY;
  end

  // Payload capture; not reset because the occupancy bit qualifies it.
  always_ff @(posedge clk) begin
    if (accept) begin
      held_addr <= addr;
      held_data <= data;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter sharing the register file's single write port between
// the ALU path (A) and the load path (M). Writes commit in acceptance order.
// Optional pending-write scoreboard: define REGFILE_WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);

  logic                 a_full, m_full;
  logic                 a_grant, m_grant;
  logic                 a_accept, m_accept;
  logic [RF_ADDR_W-1:0] a_addr, m_addr;
  logic [RF_DATA_W-1:0] a_data, m_data;
  logic                 a_older;

  wb_slot u_alu_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (bus.alu_valid),
    .addr      (bus.alu_addr),
    .data      (bus.alu_data),
    .grant     (a_grant),
    .ready     (bus.alu_ready),
    .accept    (a_accept),
    .full      (a_full),
    .held_addr (a_addr),
    .held_data (a_data)
  );

  wb_slot u_mem_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid     (bus.mem_valid),
    .addr      (bus.mem_addr),
    .data      (bus.mem_data),
    .grant     (m_grant),
    .ready     (bus.mem_ready),
    .accept    (m_accept),
    .full      (m_full),
    .held_addr (m_addr),
    .held_data (m_data)
  );

  // A lone full slot is granted; with both full the older one goes first.
  assign a_grant = a_full && (!m_full || a_older);
  assign m_grant = m_full && (!a_full || !a_older);

  // Age tracking: a newcomer is younger than a slot still waiting; on a
  // simultaneous accept the load is treated as the earlier instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             a_older <= 1'b0;
    else if (a_accept && m_accept)          a_older <= 1'b0;
    else if (a_accept && m_full && !m_grant) a_older <= 1'b0;
    else if (m_accept && a_full && !a_grant) a_older <= 1'b1;
  end

  assign bus.reg3_write = a_full || m_full;

  // Write-port mux from the granted slot; idle port presents zeros.
  always_comb begin
    bus.reg3_addr = '0;
    bus.reg3_bus  = '0;
    if (a_grant) begin
      bus.reg3_addr = a_addr;
      bus.reg3_bus  = a_data;
    end else if (m_grant) begin
      bus.reg3_addr = m_addr;
      bus.reg3_bus  = m_data;
    end
  end

`ifdef REGFILE_WB_SCOREBOARD_EN
  // Pending registers: destination of every held write; a same-register
  // refill keeps its bit set because the slot stays full.
  always_comb begin
    bus.pending_mask = '0;
    if (a_full) bus.pending_mask = bus.pending_mask | addr_onehot(a_addr);
    if (m_full) bus.pending_mask = bus.pending_mask | addr_onehot(m_addr);
  end
`else
  assign bus.pending_mask = '0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port (reg3: write strobe, 4-bit address, 16-bit data) between two writeback sources: the ALU result path (source A) and the memory-load path (source M). Each source has a one-entry holding slot behind a valid/ready handshake. A per-cycle age-ordered grant drives the write port, so register writes always commit in acceptance order. An optional pending-write scoreboard lets decode stall on read-after-write hazards.

## Interface
- No parameters. Data width is 16 and address width is 4, both fixed by the register file.
- clk  in  1  rising-edge clock, shared with register_file.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  source A offers a write.
- alu_ready  out  1  source A slot can accept.
- alu_addr  in  4  source A destination register.
- alu_data  in  16  source A write value.
- mem_valid  in  1  source M offers a write.
- mem_ready  out  1  source M slot can accept.
- mem_addr  in  4  source M destination register.
- mem_data  in  16  source M write value.
- reg3_write  out  1  write strobe to register_file.
- reg3_addr  out  4  write address to register_file.
- reg3_bus  out  16  write data to register_file.
- pending_mask  out  16  bit i is set while a write to register i is held (scoreboard).

## Operation
- Each slot is either EMPTY or FULL. A transfer happens on a rising edge where valid && ready; the slot then becomes FULL and latches addr and data.
- ready = slot EMPTY || slot granted this cycle. This permits drain and refill on the same edge, giving one write per cycle per source at steady state.
- Grant, combinational from registered state:
  - Only one slot FULL: that slot is granted.
  - Both FULL: the older slot is granted. Age is tracked by a 1-bit register, a_older.
- a_older update:
  - Only A is accepted while M stays FULL and ungranted: a_older=0.
  - Only M is accepted while A stays FULL and ungranted: a_older=1.
  - Both accepted on the same edge: a_older=0, so M is older. The load belongs to the earlier instruction by pipeline convention.
- Write port outputs:
  - reg3_write = any slot FULL.
  - reg3_addr and reg3_bus are muxed from the granted slot.
  - When no slot is FULL, reg3_addr=0 and reg3_bus=0.
- The granted slot becomes EMPTY on the next edge unless it refills on that edge.
- Same-address entries in both slots are legal. The older value is written first and the younger value second, so the final register content is the younger value.

## Timing
- Latency from acceptance edge N: reg3_write is high during cycle N+1, and register_file captures on edge N+1.
- An ungranted slot waits exactly one extra cycle per older competitor. The worst case is 2 cycles from acceptance to commit.
- Reset values while rst_n is low, asynchronously:
  - both slots EMPTY, a_older=0;
  - reg3_write=0, reg3_addr=0, reg3_bus=0;
  - pending_mask=0;
  - alu_ready=1, mem_ready=1.
- Reset asserted mid-operation discards held writes. No partial write is issued after rst_n deasserts.
- Outputs are glitch-relevant only at the clock edge. register_file samples reg3_* on the rising edge.

## Configuration
- `REGFILE_WB_SCOREBOARD_EN` defined:
  - pending_mask = OR of one-hot(addr) over FULL slots.
  - The bit clears on the edge the write commits, unless a refill targets the same register.
- Undefined: pending_mask is tied to 16'h0000 and no decode logic is generated.

## Structure
- Shared package holds:
  - RF_DATA_W=16, RF_ADDR_W=4, RF_NUM_REGS=16;
  - slot state constants SLOT_EMPTY=1'b0 and SLOT_FULL=1'b1.
- One sub-module: wb_slot. Instantiate it twice. It holds state, addr and data, implements the ready equation, and takes a grant input.
- The top level holds a_older, grant logic, the output mux and the optional scoreboard.

## Test plan
- After reset: alu_valid=1, addr=3, data=16'h1234 for one cycle. Required: reg3_write=1, reg3_addr=3, reg3_bus=16'h1234 next cycle; register 3 reads 16'h1234 via reg1_bus afterwards.
- Both valid on the same edge, A→r5=16'hAAAA and M→r5=16'hBBBB. Required: M written on the first cycle, A on the second; r5 ends at 16'hAAAA.
- M held FULL, then A accepted one cycle later. Required: M commits first; alu_ready=0 until A's slot drains.
- Streaming: alu_valid held high for 8 cycles with addresses 0..7 and M idle. Required: alu_ready stays 1 and 8 consecutive writes land with no bubbles.
- rst_n pulsed low while both slots are FULL. Required: reg3_write drops to 0 asynchronously, no write after release, and both registers keep their old values.
- With `REGFILE_WB_SCOREBOARD_EN` defined: A→r9 accepted. Required: pending_mask=16'h0200 for exactly one cycle, then 16'h0000. Without the macro, pending_mask is always 0.
